count_step_checker: RTL and testbench
=====================================

// Module: count_step_checker
// PURPOSE
//   Sits directly downstream of up_counter_3_bit and consumes its Y output as
//   cnt_in. Checks that every valid sample is the previous sample plus one,
//   modulo 2**CNT_W. It must first lock onto a clean increment run. Once
//   locked, it counts wrap-arounds (max->0) and step errors, giving bring-up
//   visibility of counter health.
// PARAMETERS
//   CNT_W   3  width of the monitored count value
//   WRAP_W  8  width of the wrap counter (saturating)
//   ERR_W   4  width of the step-error counter (saturating)
//   LOCK_N  2  consecutive correct steps needed to enter LOCKED (>=1)
// PORTS
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   cnt_in      in   CNT_W   count value from the upstream counter
//   cnt_vld     in   1       cnt_in is sampled on this edge
//   clr         in   1       synchronous clear of state and counters
//   locked      out  1       1 while FSM is in S_LOCKED
//   wrap_pulse  out  1       one-cycle pulse: a wrap was seen while locked
//   wrap_cnt    out  WRAP_W  number of wraps seen while locked
//   err         out  1       one-cycle pulse: a bad step was seen while locked
//   err_cnt     out  ERR_W   number of bad steps seen
// BEHAVIOUR
//   - All outputs are registered. Reset (rst_n=0, async) gives: state=S_IDLE,
//     prev=0, good_run=0, locked=0, wrap_pulse=0, wrap_cnt=0, err=0, err_cnt=0.
//   - Priority: rst_n > clr > cnt_vld. clr has the same effect as reset but is
//     synchronous. A cnt_vld arriving in the same cycle as clr is discarded.
//   - good step: cnt_in == prev+1 mod 2**CNT_W (so max->0 is a good step).
//     wrap: prev == 2**CNT_W-1 and cnt_in == 0.
//   - On every accepted sample, prev <= cnt_in, in every state.
//   - S_IDLE: on cnt_vld, go to S_LOCKING with good_run=0. No flags.
//   - S_LOCKING, on each cnt_vld:
//       good step: good_run+1; if that reaches LOCK_N, go to S_LOCKED and
//         clear good_run.
//       bad step: good_run=0. No err pulse, no err_cnt change.
//       Wraps are not counted in this state.
//   - S_LOCKED, on each cnt_vld:
//       good step: stay in S_LOCKED. On a wrap, wrap_pulse=1 for one cycle
//         and wrap_cnt increments.
//       bad step: err=1 for one cycle, err_cnt increments, go to S_LOCKING
//         with good_run=0.
//   - Latency: pulses and counter updates appear one clock after the sampling
//     edge. locked changes on the same edge as the state register.
//   - Both counters saturate at all-ones and never wrap.
//   - No cnt_vld: state and counters hold; pulses return to 0.
//   - rst_n asserted mid-run: everything clears immediately, without waiting
//     for a clock edge.
// CONFIGURATION
//   STEP_HOLD_EN defined: cnt_in == prev is legal in S_LOCKING and S_LOCKED.
//     No err, good_run unchanged, state unchanged. This tolerates a stalled
//     counter.
//   STEP_HOLD_EN undefined: cnt_in == prev is a bad step, handled as above.
// TESTING (defaults unless noted)
//   1 Reset, then vld samples 0,1,2 on consecutive clocks -> locked=1 after the
//     edge sampling 2; err_cnt=0, wrap_cnt=0.
//   2 Locked, samples 6,7,0,1 -> wrap_pulse high exactly one cycle after the
//     sample 0 edge; wrap_cnt=1; no err.
//   3 Locked at 3, sample 5 -> err pulse for one cycle, err_cnt=1, locked=0.
//     Then 6,7 -> locked=1 again; err_cnt stays 1.
//   4 WRAP_W=2, locked, count 0..7 repeated five times -> wrap_cnt stops at 3;
//     wrap_pulse still fires on every wrap.
//   5 Locked, samples 4,4,5: with STEP_HOLD_EN -> no err, locked stays 1.
//     Without it -> err pulse, err_cnt=1, locked=0.
//   6 rst_n=0 asynchronously mid-run -> all outputs 0 at once. Separately,
//     clr=1 together with cnt_vld -> S_IDLE, counters 0, sample ignored.

Source files
------------

// File: rtl/count_step_checker.sv
// Step checker for an upstream counter: locks onto a clean +1 run, then counts wraps and bad steps.
// Optional macro STEP_HOLD_EN: a repeated value (cnt_in == prev) is tolerated once locking has started.
module count_step_checker #(
  parameter int CNT_W  = 3,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4,
  parameter int LOCK_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_vld,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int RUN_W = (LOCK_N > 1) ? $clog2(LOCK_N + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKING,
    S_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [RUN_W-1:0]   good_run_q, good_run_d;
  logic               locked_q, locked_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               good_step, is_wrap, is_hold;
  logic [RUN_W-1:0]   run_inc;

  assign good_step = (cnt_in == CNT_W'(prev_q + CNT_W'(1)));
  assign is_wrap   = (prev_q == '1) && (cnt_in == '0);
  assign run_inc   = good_run_q + RUN_W'(1);

`ifdef STEP_HOLD_EN
  assign is_hold = (cnt_in == prev_q);
`else
  assign is_hold = 1'b0;
`endif

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_run_d   = good_run_q;
    wrap_cnt_d   = wrap_cnt_q;
    err_cnt_d    = err_cnt_q;
    wrap_pulse_d = 1'b0;
    err_d        = 1'b0;

    if (clr) begin
      state_d    = S_IDLE;
      prev_d     = '0;
      good_run_d = '0;
      wrap_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (cnt_vld) begin
      prev_d = cnt_in;
      case (state_q)
        S_IDLE: begin
          state_d    = S_LOCKING;
          good_run_d = '0;
        end
        S_LOCKING: begin
          if (is_hold) begin
            good_run_d = good_run_q;
          end else if (good_step) begin
            if (run_inc == RUN_W'(LOCK_N)) begin
              state_d    = S_LOCKED;
              good_run_d = '0;
            end else begin
              good_run_d = run_inc;
            end
          end else begin
            good_run_d = '0;
          end
        end
        S_LOCKED: begin
          if (is_hold) begin
            state_d = S_LOCKED;
          end else if (good_step) begin
            if (is_wrap) begin
              wrap_pulse_d = 1'b1;
              if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
            end
          end else begin
            err_d      = 1'b1;
            state_d    = S_LOCKING;
            good_run_d = '0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prev_q       <= '0;
      good_run_q   <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_run_q   <= good_run_d;
      locked_q     <= locked_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_count_step_checker.sv
// Self-checking bench for count_step_checker: a default instance and a narrow-counter instance
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_count_step_checker;

  localparam int M      = 8;   // 2**CNT_W
  localparam int LOCK_N = 2;
  localparam int WMAX_A = 255, EMAX_A = 15;
  localparam int WMAX_B = 3,   EMAX_B = 3;
`ifdef STEP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clr, cnt_vld;
  logic [2:0] cnt_in;

  logic       a_locked, a_wp, a_err;
  logic [7:0] a_wc;
  logic [3:0] a_ec;
  logic       b_locked, b_wp, b_err;
  logic [1:0] b_wc;
  logic [1:0] b_ec;

  count_step_checker dut_a (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
    .locked(a_locked), .wrap_pulse(a_wp), .wrap_cnt(a_wc), .err(a_err), .err_cnt(a_ec)
  );

  count_step_checker #(.WRAP_W(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
    .locked(b_locked), .wrap_pulse(b_wp), .wrap_cnt(b_wc), .err(b_err), .err_cnt(b_ec)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: "started" means a first sample was taken, run counts clean steps toward lock.
  bit m_started, m_locked, m_wp, m_err;
  int m_run, m_prev, m_wc_a, m_wc_b, m_ec_a, m_ec_b;

  function automatic int sat_inc(int v, int max);
    return (v < max) ? v + 1 : max;
  endfunction

  task automatic model_clear();
    m_started = 0; m_locked = 0; m_wp = 0; m_err = 0;
    m_run = 0; m_prev = 0; m_wc_a = 0; m_wc_b = 0; m_ec_a = 0; m_ec_b = 0;
  endtask

  task automatic model_step(input bit v, input int val, input bit c);
    bit good, hold;
    m_wp = 0; m_err = 0;
    if (c) begin
      model_clear();
    end else if (v) begin
      good = (val == (m_prev + 1) % M);
      hold = HOLD && (val == m_prev);
      if (!m_started) begin
        m_started = 1; m_run = 0;
      end else if (hold) begin
        // stalled counter tolerated: nothing changes
      end else if (!m_locked) begin
        if (good) begin
          m_run++;
          if (m_run == LOCK_N) begin m_locked = 1; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else if (good) begin
        if (m_prev == M - 1) begin
          m_wp = 1;
          m_wc_a = sat_inc(m_wc_a, WMAX_A);
          m_wc_b = sat_inc(m_wc_b, WMAX_B);
        end
      end else begin
        m_err = 1; m_locked = 0; m_run = 0;
        m_ec_a = sat_inc(m_ec_a, EMAX_A);
        m_ec_b = sat_inc(m_ec_b, EMAX_B);
      end
      m_prev = val;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, " a.locked"},     32'(a_locked), 32'(m_locked));
    check({ph, " a.wrap_pulse"}, 32'(a_wp),     32'(m_wp));
    check({ph, " a.wrap_cnt"},   32'(a_wc),     32'(m_wc_a));
    check({ph, " a.err"},        32'(a_err),    32'(m_err));
    check({ph, " a.err_cnt"},    32'(a_ec),     32'(m_ec_a));
    check({ph, " b.locked"},     32'(b_locked), 32'(m_locked));
    check({ph, " b.wrap_pulse"}, 32'(b_wp),     32'(m_wp));
    check({ph, " b.wrap_cnt"},   32'(b_wc),     32'(m_wc_b));
    check({ph, " b.err"},        32'(b_err),    32'(m_err));
    check({ph, " b.err_cnt"},    32'(b_ec),     32'(m_ec_b));
  endtask

  task automatic cycle(input string ph, input bit v, input int val, input bit c = 1'b0);
    logic [31:0] vv;
    vv = 32'(val);
    clr = c; cnt_vld = v; cnt_in = vv[2:0];
    @(posedge clk);
    model_step(v, val, c);
    #1;
    check_all(ph);
  endtask

  initial begin
    int r, val;
    bit v, c;

    rst_n = 1'b0; clr = 1'b0; cnt_vld = 1'b0; cnt_in = '0;
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Lock onto 0,1,2, then an idle cycle
    cycle("lock0", 1, 0);
    cycle("lock1", 1, 1);
    cycle("lock2", 1, 2);
    check("lock locked", 32'(a_locked), 32'd1);
    cycle("idle", 0, 0);

    // Wrap while locked
    for (int k = 3; k <= 7; k++) cycle("run", 1, k);
    cycle("wrap0", 1, 0);
    check("wrap pulse", 32'(a_wp), 32'd1);
    cycle("wrap1", 1, 1);

    // Bad step 3->5, then relock with 6,7
    cycle("pre2", 1, 2);
    cycle("pre3", 1, 3);
    cycle("bad5", 1, 5);
    check("bad err", 32'(a_err), 32'd1);
    cycle("re6", 1, 6);
    cycle("re7", 1, 7);
    check("relock", 32'(a_locked), 32'd1);

    // Repeated value 4,4,5 (outcome depends on STEP_HOLD_EN)
    for (int k = 0; k <= 4; k++) cycle("toward4", 1, k);
    cycle("hold4", 1, 4);
    cycle("hold5", 1, 5);
    cycle("hold6", 1, 6);
    cycle("hold7", 1, 7);
    cycle("hold0", 1, 0);
    cycle("hold1", 1, 1);

    // Five full laps: narrow wrap counter saturates at 3
    for (int rep = 0; rep < 5; rep++)
      for (int k = 0; k < M; k++) cycle("lap", 1, (k + 2) % M);
    check("b wrap sat", 32'(b_wc), 32'd3);

    // Asynchronous reset mid-run
    #3 rst_n = 1'b0;
    #1 model_clear();
    check_all("async_rst");
    @(negedge clk) rst_n = 1'b1;

    // clr with a coincident sample: sample discarded
    cycle("c0", 1, 3);
    cycle("c1", 1, 4);
    cycle("c2", 1, 5);
    cycle("clr", 1, 5, 1);
    cycle("after_clr", 1, 1);
    cycle("after_clr2", 1, 2);

    // Randomised stream
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      v = (r < 85);
      r = $urandom_range(0, 99);
      if (r < 70)      val = (m_prev + 1) % M;
      else if (r < 80) val = m_prev;
      else             val = $urandom_range(0, M - 1);
      c = ($urandom_range(0, 59) == 0);
      cycle("rand", v, val, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
